// File: rtl/my9262_chain_tx_if.sv
// User-side stream and control bundle for the MY9262 chain transmitter.
// The master is the frame-buffer/command logic; the slave is the transmitter.
interface my9262_chain_tx_if #(
    parameter int WORD_BITS = 16
);
    logic                 start;
    logic                 mode;
    logic [WORD_BITS-1:0] word_data;
    logic                 word_valid;
    logic                 word_ready;
    logic                 busy;
    logic                 done;

    modport master (
        output start, mode, word_data, word_valid,
        input  word_ready, busy, done
    );

    modport slave (
        input  start, mode, word_data, word_valid,
        output word_ready, busy, done
    );
endinterface

// File: rtl/my9262_chain_tx.sv
// Serial transmitter for a daisy-chain of MY9262-class LED drivers.
// Words are shifted MSB-first on DCLK/DI, each frame is closed by a
// gray-scale latch pulse or an overlapped config latch, and GCK free-runs.
module my9262_chain_tx #(
    parameter int CHIPS       = 2,
    parameter int CH_PER_CHIP = 16,
    parameter int WORD_BITS   = 16,
    parameter int DCLK_DIV    = 1,
    parameter int GCK_DIV     = 1,
    parameter int GAP_CYC     = 2,
    parameter int LAT_CYC     = 2,
    parameter int OVR_EDGES   = 2
) (
    input  logic                    CLK_60M,
    input  logic                    RST_N,
    my9262_chain_tx_if.slave        bus,
    input  logic                    gck_en,
    output logic                    my9262_Dclk,
    output logic                    my9262_Di,
    output logic                    my9262_Lat,
    output logic                    my9262_Gck
);

    localparam int N_WORDS  = CHIPS * CH_PER_CHIP;
    localparam int N_BITS   = N_WORDS * WORD_BITS;
    localparam int BIT_W    = $clog2(N_BITS + 1);
    localparam int WORD_W   = $clog2(N_WORDS + 1);
    localparam int BIDX_W   = $clog2(WORD_BITS + 1);
    localparam int DIV_W    = $clog2(DCLK_DIV + 1);
    localparam int WAIT_MAX = (GAP_CYC > LAT_CYC) ? GAP_CYC : LAT_CYC;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam int GDIV_W   = $clog2(GCK_DIV + 1);

    localparam logic [BIT_W-1:0]  LAT_THRESH = BIT_W'(N_BITS - OVR_EDGES);
    localparam logic [BIDX_W-1:0] LAST_BIT   = BIDX_W'(WORD_BITS - 1);
    localparam logic [WORD_W-1:0] LAST_WORD  = WORD_W'(N_WORDS);
    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(DCLK_DIV - 1);
    localparam logic [WAIT_W-1:0] GAP_LAST   = WAIT_W'(GAP_CYC - 1);
    localparam logic [WAIT_W-1:0] LAT_LAST   = WAIT_W'(LAT_CYC - 1);
    localparam logic [GDIV_W-1:0] GCK_LAST   = GDIV_W'(GCK_DIV - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, GAP, LATCH, DONE} state_t;

    state_t               state_q, state_d;
    logic                 mode_q, mode_d;
    logic [WORD_BITS-1:0] shift_q, shift_d, shiftNext;
    logic [BIT_W-1:0]     bitCnt_q, bitCnt_d, bitCntInc;
    logic [BIDX_W-1:0]    bitIdx_q, bitIdx_d;
    logic [WORD_W-1:0]    wordCnt_q, wordCnt_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic [GDIV_W-1:0]    gckCnt_q, gckCnt_d;
    logic                 dclk_q, dclk_d;
    logic                 di_q, di_d;
    logic                 lat_q, lat_d;
    logic                 gck_q, gck_d;

    logic accept, divEnd, riseEv, fallEv, wordEnd, cfgMode, latSet;

    assign accept    = (state_q == LOAD) && bus.word_valid;
    assign divEnd    = (div_q == DIV_LAST);
    assign riseEv    = (state_q == SHIFT) && !dclk_q && divEnd;
    assign fallEv    = (state_q == SHIFT) && dclk_q && divEnd;
    assign wordEnd   = fallEv && (bitIdx_q == LAST_BIT);
    assign shiftNext = shift_q << 1;
    assign bitCntInc = bitCnt_q + BIT_W'(1);
    assign cfgMode   = (state_q == IDLE) ? bus.mode : mode_q;
    assign latSet    = (fallEv && (bitCntInc == LAT_THRESH)) ||
                       ((state_q == IDLE) && bus.start && (LAT_THRESH == '0));

    // Frame FSM state register.
    always_ff @(posedge CLK_60M or negedge RST_N) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Frame FSM next-state decision.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = LOAD;
            LOAD:    if (accept) state_d = SHIFT;
            SHIFT:   if (wordEnd) state_d = (wordCnt_q == LAST_WORD) ? GAP : LOAD;
            GAP:     if (wait_q == GAP_LAST) state_d = mode_q ? DONE : LATCH;
            LATCH:   if (wait_q == LAT_LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs plus next values for the datapath and pin registers.
    always_comb begin
        bus.word_ready = (state_q == LOAD);
        bus.busy       = (state_q != IDLE);
        bus.done       = (state_q == DONE);
        mode_d    = mode_q;
        shift_d   = shift_q;
        bitCnt_d  = bitCnt_q;
        bitIdx_d  = bitIdx_q;
        wordCnt_d = wordCnt_q;
        div_d     = div_q;
        dclk_d    = dclk_q;
        di_d      = di_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mode_d    = bus.mode;
                    bitCnt_d  = '0;
                    wordCnt_d = '0;
                end
            end
            LOAD: begin
                if (accept) begin
                    shift_d   = bus.word_data;
                    di_d      = bus.word_data[WORD_BITS-1];
                    wordCnt_d = wordCnt_q + WORD_W'(1);
                    bitIdx_d  = '0;
                    div_d     = '0;
                end
            end
            SHIFT: begin
                div_d = divEnd ? '0 : div_q + DIV_W'(1);
                if (riseEv) dclk_d = 1'b1;
                if (fallEv) begin
                    dclk_d   = 1'b0;
                    shift_d  = shiftNext;
                    di_d     = shiftNext[WORD_BITS-1];
                    bitCnt_d = bitCntInc;
                    bitIdx_d = bitIdx_q + BIDX_W'(1);
                end
            end
            default: ;
        endcase

        if ((state_d == state_q) && ((state_q == GAP) || (state_q == LATCH)))
            wait_d = wait_q + WAIT_W'(1);
        else
            wait_d = '0;

        case (state_d)
            LATCH:       lat_d = 1'b1;
            LOAD, SHIFT: lat_d = cfgMode && (lat_q || latSet);
            default:     lat_d = 1'b0;
        endcase

        gckCnt_d = gckCnt_q;
        gck_d    = gck_q;
        if (!gck_en) begin
            gckCnt_d = '0;
            gck_d    = 1'b0;
        end else if (gckCnt_q == GCK_LAST) begin
            gckCnt_d = '0;
            gck_d    = ~gck_q;
        end else begin
            gckCnt_d = gckCnt_q + GDIV_W'(1);
        end
    end

    // Datapath, counters and registered chip pins.
    always_ff @(posedge CLK_60M or negedge RST_N) begin
        if (!RST_N) begin
            mode_q    <= 1'b0;
            shift_q   <= '0;
            bitCnt_q  <= '0;
            bitIdx_q  <= '0;
            wordCnt_q <= '0;
            div_q     <= '0;
            wait_q    <= '0;
            gckCnt_q  <= '0;
            dclk_q    <= 1'b0;
            di_q      <= 1'b0;
            lat_q     <= 1'b0;
            gck_q     <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            shift_q   <= shift_d;
            bitCnt_q  <= bitCnt_d;
            bitIdx_q  <= bitIdx_d;
            wordCnt_q <= wordCnt_d;
            div_q     <= div_d;
            wait_q    <= wait_d;
            gckCnt_q  <= gckCnt_d;
            dclk_q    <= dclk_d;
            di_q      <= di_d;
            lat_q     <= lat_d;
            gck_q     <= gck_d;
        end
    end

    assign my9262_Dclk = dclk_q;
    assign my9262_Di   = di_q;
    assign my9262_Lat  = lat_q;
    assign my9262_Gck  = gck_q;

endmodule

// File: tb/tb_my9262_chain_tx.sv
// Directed bench for my9262_chain_tx: one chip, two 16-bit words, DCLK_DIV=1,
// GAP_CYC=2, LAT_CYC=2, OVR_EDGES=2, GCK_DIV=3.
module tb_my9262_chain_tx;

    logic CLK_60M = 1'b0;
    logic RST_N   = 1'b0;
    logic gck_en  = 1'b0;
    logic Dclk, Di, Lat, Gck;

    my9262_chain_tx_if #(.WORD_BITS(16)) busIf();

    my9262_chain_tx #(
        .CHIPS(1), .CH_PER_CHIP(2), .WORD_BITS(16), .DCLK_DIV(1),
        .GCK_DIV(3), .GAP_CYC(2), .LAT_CYC(2), .OVR_EDGES(2)
    ) dut (
        .CLK_60M     (CLK_60M),
        .RST_N       (RST_N),
        .bus         (busIf),
        .gck_en      (gck_en),
        .my9262_Dclk (Dclk),
        .my9262_Di   (Di),
        .my9262_Lat  (Lat),
        .my9262_Gck  (Gck)
    );

    // 10-unit clock period.
    always #5 CLK_60M = ~CLK_60M;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Cycle index used to time events relative to each other.
    always @(posedge CLK_60M) cyc <= cyc + 1;

    logic [31:0] capBits, capLat;
    int riseCnt, lastFallCyc, latRiseCyc, latHigh, doneCnt, firstRiseCyc;
    bit firstRiseSeen;
    logic prevDclk = 1'b0;
    logic prevLat  = 1'b0;

    // Capture DI and LAT at every DCLK rising edge, as the chip sees them.
    always @(posedge Dclk) begin
        capBits = {capBits[30:0], Di};
        capLat  = {capLat[30:0], Lat};
        riseCnt++;
    end

    // Per-cycle observation of pin and handshake activity.
    always @(negedge CLK_60M) begin
        if (prevDclk && !Dclk) lastFallCyc = cyc;
        if (Dclk && !prevDclk && !firstRiseSeen) begin
            firstRiseCyc  = cyc;
            firstRiseSeen = 1'b1;
        end
        if (Lat && !prevLat) latRiseCyc = cyc;
        if (Lat) latHigh++;
        if (busIf.done) doneCnt++;
        prevDclk = Dclk;
        prevLat  = Lat;
    end

    int  startCyc, acceptCyc, doneCyc, stallRises;
    bit  busyAt1, readyAt1, frameTimeout, stallDclkBad;

    task automatic clearMon();
        #1;
        capBits = '0; capLat = '0; riseCnt = 0; latHigh = 0; doneCnt = 0;
        lastFallCyc = -1; latRiseCyc = -1; firstRiseCyc = -1; firstRiseSeen = 1'b0;
    endtask

    task automatic runFrame(input logic m, input logic [15:0] w0, input logic [15:0] w1,
                            input int stall, input bit extraStart);
        bit got;
        int r0;
        clearMon();
        frameTimeout = 1'b0; stallDclkBad = 1'b0; stallRises = 0;
        @(negedge CLK_60M);
        busIf.start = 1'b1; busIf.mode = m; startCyc = cyc;
        @(negedge CLK_60M);
        busIf.start = 1'b0;
        busyAt1 = busIf.busy; readyAt1 = busIf.word_ready;
        for (int w = 0; w < 2; w++) begin
            if (w == 1 && stall > 0) begin
                got = 1'b0;
                for (int k = 0; k < 200; k++) begin
                    if (busIf.word_ready) begin got = 1'b1; break; end
                    @(negedge CLK_60M);
                end
                if (!got) frameTimeout = 1'b1;
                r0 = riseCnt;
                for (int s = 0; s < stall; s++) begin
                    if (Dclk !== 1'b0) stallDclkBad = 1'b1;
                    @(negedge CLK_60M);
                end
                stallRises = riseCnt - r0;
            end
            busIf.word_data  = (w == 0) ? w0 : w1;
            busIf.word_valid = 1'b1;
            got = 1'b0;
            for (int k = 0; k < 200; k++) begin
                if (busIf.word_ready) begin got = 1'b1; break; end
                @(negedge CLK_60M);
            end
            if (!got) frameTimeout = 1'b1;
            if (w == 0) acceptCyc = cyc;
            @(negedge CLK_60M);
            busIf.word_valid = 1'b0;
            if (extraStart && w == 0) begin
                busIf.start = 1'b1;
                @(negedge CLK_60M);
                busIf.start = 1'b0;
            end
        end
        got = 1'b0;
        for (int k = 0; k < 500; k++) begin
            if (busIf.done) begin got = 1'b1; doneCyc = cyc; break; end
            @(negedge CLK_60M);
        end
        if (!got) frameTimeout = 1'b1;
        repeat (3) @(negedge CLK_60M);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge CLK_60M);
        total++;
        if ({Dclk, Di, Lat, Gck, busIf.word_ready, busIf.busy, busIf.done} !== 7'b0) begin
            bad++;
            $display("[TB] FAIL reset_values: got %b want 0000000",
                     {Dclk, Di, Lat, Gck, busIf.word_ready, busIf.busy, busIf.done});
        end
        RST_N = 1'b1;
        repeat (2) @(negedge CLK_60M);
    endtask

    task automatic test_gray();
        runFrame(1'b0, 16'h0064, 16'hA5F0, 0, 1'b0);
        total++; if (frameTimeout !== 1'b0) begin bad++; $display("[TB] FAIL gray_timeout: got %0d want 0", frameTimeout); end
        total++; if (busyAt1 !== 1'b1) begin bad++; $display("[TB] FAIL gray_busy_t1: got %0d want 1", busyAt1); end
        total++; if (readyAt1 !== 1'b1) begin bad++; $display("[TB] FAIL gray_ready_t1: got %0d want 1", readyAt1); end
        total++; if (firstRiseCyc - acceptCyc !== 2) begin bad++; $display("[TB] FAIL gray_first_rise: got %0d want 2", firstRiseCyc - acceptCyc); end
        total++; if (riseCnt !== 32) begin bad++; $display("[TB] FAIL gray_rises: got %0d want 32", riseCnt); end
        total++; if (capBits !== 32'h0064A5F0) begin bad++; $display("[TB] FAIL gray_bits: got %h want 0064a5f0", capBits); end
        total++; if (capLat !== 32'h0) begin bad++; $display("[TB] FAIL gray_lat_at_rises: got %h want 00000000", capLat); end
        total++; if (latRiseCyc - lastFallCyc !== 2) begin bad++; $display("[TB] FAIL gray_lat_gap: got %0d want 2", latRiseCyc - lastFallCyc); end
        total++; if (latHigh !== 2) begin bad++; $display("[TB] FAIL gray_lat_width: got %0d want 2", latHigh); end
        total++; if (doneCyc - latRiseCyc !== 2) begin bad++; $display("[TB] FAIL gray_done_after_lat: got %0d want 2", doneCyc - latRiseCyc); end
        // Frame length counted inclusive of the start cycle and the done cycle.
        total++; if (doneCyc - startCyc + 1 !== 72) begin bad++; $display("[TB] FAIL gray_frame_len: got %0d want 72", doneCyc - startCyc + 1); end
        total++; if (doneCnt !== 1) begin bad++; $display("[TB] FAIL gray_done_count: got %0d want 1", doneCnt); end
    endtask

    task automatic test_config();
        runFrame(1'b1, 16'h0064, 16'hA5F0, 0, 1'b0);
        total++; if (frameTimeout !== 1'b0) begin bad++; $display("[TB] FAIL cfg_timeout: got %0d want 0", frameTimeout); end
        total++; if (riseCnt !== 32) begin bad++; $display("[TB] FAIL cfg_rises: got %0d want 32", riseCnt); end
        total++; if (capBits !== 32'h0064A5F0) begin bad++; $display("[TB] FAIL cfg_bits: got %h want 0064a5f0", capBits); end
        total++; if (capLat !== 32'h00000003) begin bad++; $display("[TB] FAIL cfg_lat_at_rises: got %h want 00000003", capLat); end
        total++; if (latHigh !== 4) begin bad++; $display("[TB] FAIL cfg_lat_cycles: got %0d want 4", latHigh); end
        total++; if (doneCyc - lastFallCyc !== 2) begin bad++; $display("[TB] FAIL cfg_done_after_gap: got %0d want 2", doneCyc - lastFallCyc); end
        total++; if (doneCnt !== 1) begin bad++; $display("[TB] FAIL cfg_done_count: got %0d want 1", doneCnt); end
    endtask

    task automatic test_underrun();
        runFrame(1'b0, 16'h0064, 16'hA5F0, 10, 1'b0);
        total++; if (frameTimeout !== 1'b0) begin bad++; $display("[TB] FAIL under_timeout: got %0d want 0", frameTimeout); end
        total++; if (stallDclkBad !== 1'b0) begin bad++; $display("[TB] FAIL under_dclk_low: got %0d want 0", stallDclkBad); end
        total++; if (stallRises !== 0) begin bad++; $display("[TB] FAIL under_stall_rises: got %0d want 0", stallRises); end
        total++; if (capBits !== 32'h0064A5F0) begin bad++; $display("[TB] FAIL under_bits: got %h want 0064a5f0", capBits); end
        total++; if (doneCyc - startCyc + 1 !== 82) begin bad++; $display("[TB] FAIL under_frame_len: got %0d want 82", doneCyc - startCyc + 1); end
        total++; if (doneCnt !== 1) begin bad++; $display("[TB] FAIL under_done_count: got %0d want 1", doneCnt); end
    endtask

    task automatic test_ignore();
        bit idleBad;
        int r0;
        clearMon();
        idleBad = 1'b0;
        @(negedge CLK_60M);
        busIf.word_data = 16'hFFFF; busIf.word_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK_60M);
            if (busIf.word_ready !== 1'b0 || busIf.busy !== 1'b0) idleBad = 1'b1;
        end
        busIf.word_valid = 1'b0;
        total++; if (idleBad !== 1'b0) begin bad++; $display("[TB] FAIL ign_idle_valid: got %0d want 0", idleBad); end
        total++; if (riseCnt !== 0) begin bad++; $display("[TB] FAIL ign_idle_rises: got %0d want 0", riseCnt); end
        runFrame(1'b0, 16'h1234, 16'h8001, 0, 1'b1);
        total++; if (capBits !== 32'h12348001) begin bad++; $display("[TB] FAIL ign_bits: got %h want 12348001", capBits); end
        total++; if (doneCnt !== 1) begin bad++; $display("[TB] FAIL ign_done_count: got %0d want 1", doneCnt); end
        total++; if (doneCyc - startCyc + 1 !== 72) begin bad++; $display("[TB] FAIL ign_frame_len: got %0d want 72", doneCyc - startCyc + 1); end
        r0 = riseCnt;
        idleBad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK_60M);
            if (busIf.busy !== 1'b0) idleBad = 1'b1;
        end
        total++; if (idleBad !== 1'b0 || riseCnt !== r0) begin bad++; $display("[TB] FAIL ign_after_frame: busy_seen %0d rises %0d want 0 and %0d", idleBad, riseCnt, r0); end
    endtask

    task automatic test_gck();
        int rises[3];
        int nR, hiRun, hiWidth;
        logic prevG;
        bit got, lowBad;
        gck_en = 1'b0;
        repeat (2) @(negedge CLK_60M);
        gck_en = 1'b1;
        nR = 0; hiRun = 0; hiWidth = -1; prevG = Gck;
        for (int k = 0; k < 60; k++) begin
            @(negedge CLK_60M);
            if (Gck && !prevG && nR < 3) begin rises[nR] = cyc; nR++; end
            if (Gck) hiRun++;
            else if (prevG) begin hiWidth = hiRun; hiRun = 0; end
            prevG = Gck;
        end
        total++; if (nR !== 3) begin bad++; $display("[TB] FAIL gck_rise_count: got %0d want 3", nR); end
        else begin
            total++; if (rises[1] - rises[0] !== 6) begin bad++; $display("[TB] FAIL gck_period_a: got %0d want 6", rises[1] - rises[0]); end
            total++; if (rises[2] - rises[1] !== 6) begin bad++; $display("[TB] FAIL gck_period_b: got %0d want 6", rises[2] - rises[1]); end
        end
        total++; if (hiWidth !== 3) begin bad++; $display("[TB] FAIL gck_high_width: got %0d want 3", hiWidth); end
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (Gck === 1'b1) begin got = 1'b1; break; end
            @(negedge CLK_60M);
        end
        total++; if (got !== 1'b1) begin bad++; $display("[TB] FAIL gck_wait_high: got %0d want 1", got); end
        gck_en = 1'b0;
        @(negedge CLK_60M);
        total++; if (Gck !== 1'b0) begin bad++; $display("[TB] FAIL gck_forced_low: got %0d want 0", Gck); end
        lowBad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK_60M);
            if (Gck !== 1'b0) lowBad = 1'b1;
        end
        total++; if (lowBad !== 1'b0) begin bad++; $display("[TB] FAIL gck_stays_low: got %0d want 0", lowBad); end
    endtask

    task automatic test_reset_midframe();
        bit got, postBad;
        int r0;
        clearMon();
        gck_en = 1'b1;
        @(negedge CLK_60M);
        busIf.start = 1'b1; busIf.mode = 1'b0;
        @(negedge CLK_60M);
        busIf.start = 1'b0;
        busIf.word_data = 16'hFFFF; busIf.word_valid = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (busIf.word_ready) begin got = 1'b1; break; end
            @(negedge CLK_60M);
        end
        @(negedge CLK_60M);
        busIf.word_valid = 1'b0;
        for (int k = 0; k < 20 && got; k++) begin
            if (Dclk === 1'b1) break;
            @(negedge CLK_60M);
        end
        total++; if (got !== 1'b1 || Dclk !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_reach_shift: ready %0d dclk %0d want 1 and 1", got, Dclk); end
        #2;
        RST_N = 1'b0;
        #1;
        total++;
        if ({Dclk, Di, Lat, Gck, busIf.word_ready, busIf.busy, busIf.done} !== 7'b0) begin
            bad++;
            $display("[TB] FAIL rstmid_async_clear: got %b want 0000000",
                     {Dclk, Di, Lat, Gck, busIf.word_ready, busIf.busy, busIf.done});
        end
        gck_en = 1'b0;
        repeat (2) @(negedge CLK_60M);
        RST_N = 1'b1;
        r0 = riseCnt;
        postBad = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK_60M);
            if (busIf.busy !== 1'b0 || Lat !== 1'b0 || Dclk !== 1'b0) postBad = 1'b1;
        end
        total++; if (postBad !== 1'b0 || riseCnt !== r0) begin bad++; $display("[TB] FAIL rstmid_quiet_after: activity %0d rises %0d want 0 and %0d", postBad, riseCnt, r0); end
    endtask

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scenario sequence.
    initial begin
        busIf.start = 1'b0; busIf.mode = 1'b0;
        busIf.word_data = '0; busIf.word_valid = 1'b0;
        capBits = '0; capLat = '0; riseCnt = 0; latHigh = 0; doneCnt = 0;
        lastFallCyc = -1; latRiseCyc = -1; firstRiseCyc = -1; firstRiseSeen = 1'b0;
        test_reset();
        test_gray();
        test_config();
        test_underrun();
        test_ignore();
        test_gck();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/my9262_chain_tx.md
# my9262_chain_tx

Parametrised serial transmitter for a daisy-chain of MY9262-class constant-current LED drivers. It accepts gray-scale or configuration words from user logic over a valid/ready stream and shifts each frame MSB-first on DCLK/DI. It closes each frame with the LAT sequence for the selected mode and generates a free-running GCK. It sits between the frame-buffer/command logic and the LED board connector, and replaces the fixed 32-word, single-mode transmitter.

## Interface
Parameters:
- CHIPS, 2, number of cascaded driver chips.
- CH_PER_CHIP, 16, channels (words) per chip.
- WORD_BITS, 16, bits per word.
- DCLK_DIV, 1, CLK_60M cycles per DCLK half-period (≥1).
- GCK_DIV, 1, CLK_60M cycles per GCK half-period (≥1).
- GAP_CYC, 2, idle cycles between the last DCLK fall and the latch phase (≥1).
- LAT_CYC, 2, LAT high width for a gray-scale latch (≥1).
- OVR_EDGES, 2, DCLK rising edges with LAT held high for a global (config) latch (1..WORD_BITS).

Ports:
- CLK_60M  in  1  system clock; reset RST_N, asynchronous, active-low; clock CLK_60M.
- RST_N  in  1  asynchronous active-low reset.
- start  in  1  one-cycle frame request; honoured only while busy=0.
- mode  in  1  sampled with start: 0 = gray-scale frame, 1 = config frame.
- word_data  in  WORD_BITS  next word; the first word accepted goes to the farthest chip.
- word_valid  in  1  word_data valid.
- word_ready  out  1  block accepts word_data this cycle.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at the end of a frame.
- gck_en  in  1  enables GCK generation.
- my9262_Dclk, my9262_Di, my9262_Lat, my9262_Gck  out  1 each  registered chip pins.

## Operation
- N_WORDS = CHIPS*CH_PER_CHIP. N_BITS = N_WORDS*WORD_BITS. The bit counter width is clog2(N_BITS+1) and the word counter width is clog2(N_WORDS+1).
- States: IDLE → LOAD → SHIFT → (LOAD | GAP) → (LATCH | DONE) → DONE → IDLE.
- IDLE: when start=1, capture mode and go to LOAD; set busy.
- LOAD: word_ready=1. On word_valid&word_ready, load shift_reg with word_data and go to SHIFT. If word_valid is low (underrun), DCLK stays low and the frame stalls indefinitely without error.
- SHIFT: DI = shift_reg MSB. Each bit is DCLK low for DCLK_DIV cycles, then high for DCLK_DIV cycles. shift_reg shifts left (zero fill) on each DCLK falling edge. After WORD_BITS bits, go to LOAD if words remain, else go to GAP.
- Config mode: LAT rises together with the DCLK low phase that precedes rising edge number N_BITS−OVR_EDGES+1. LAT stays high through the final falling edge, then drops on GAP entry. The LATCH state is skipped.
- Gray-scale mode: LAT stays low during shifting. GAP holds for GAP_CYC cycles, then LATCH drives LAT high for LAT_CYC cycles.
- DONE: done=1 for one cycle, busy drops, return to IDLE.
- GCK: toggles every GCK_DIV cycles while gck_en=1. When gck_en=0 it is forced low on the next cycle. GCK runs independently of the frame FSM.
- start while busy=1 is ignored. word_valid outside LOAD is ignored.

## Timing
- Reset values: Dclk=0, Di=0, Lat=0, Gck=0, word_ready=0, busy=0, done=0. State = IDLE and all counters are 0.
- start at cycle t: busy=1 and word_ready=1 at t+1.
- Word accepted at cycle a: Di holds the MSB from a+1, and the first DCLK rise is at a+1+DCLK_DIV.
- DI setup and hold to DCLK rise are each DCLK_DIV cycles.
- Between words, DCLK stays low for at least one extra cycle (the LOAD state).
- Minimum frame length with no stalls, gray-scale mode: N_WORDS*(2*WORD_BITS*DCLK_DIV+1) + GAP_CYC + LAT_CYC + 2 cycles from start to done.
- Reset mid-frame: all outputs return to their reset values immediately. No partial latch is issued.

## Test plan
- Reset: assert RST_N=0 mid-SHIFT → all outputs are 0 asynchronously. After release, busy=0 and there is no DCLK activity.
- Gray-scale frame, CHIPS=1, CH_PER_CHIP=2, WORD_BITS=16, DCLK_DIV=1, words 0x0064 then 0xA5F0 → 32 rises on Di 0000000001100100 1010010111110000. LAT stays low while shifting, then goes high for exactly 2 cycles starting 2 cycles after the last fall. One done pulse follows.
- Config frame, same parameters with OVR_EDGES=2 → LAT is high across DCLK rises 31 and 32 only, there is no post-gap LAT pulse, and done follows.
- Underrun: hold word_valid low for 10 cycles before word 2 → DCLK stays low for those 10 cycles and the bitstream is unchanged.
- start pulsed while busy=1, and word_valid asserted in IDLE → both are ignored; the frame count and bitstream are unaffected.
- GCK_DIV=3, gck_en toggled → period of 6 cycles while enabled; Gck=0 one cycle after gck_en falls.
